axi_lite_read_arbiter: RTL and testbench

Shares one AXI4-Lite read master channel between NUM_REQ local requesters using round-robin arbitration.
- Each requester presents an address and protection value through a valid/ready request port.
- The block sequences the AR and R phases, then returns RDATA/RRESP to the granted requester.
- It sits between the local read clients and the read master port facing slave_file.
- One transaction is outstanding at a time, which matches AXI4-Lite single-beat semantics.

---
 rtl/axi_lite_read_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_axi_lite_read_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_read_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite read master among NUM_REQ local requesters.
// A four-state FSM sequences the AR, R and local response phases, one transaction at a time.
module axi_lite_read_arbiter #(
  parameter int NUM_REQ            = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int CNT_WIDTH          = 8
) (
  input  logic                                    aclk,
  input  logic                                    aresetn,
  input  logic [NUM_REQ-1:0]                      req_valid,
  input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*3-1:0]                    req_prot,
  output logic [NUM_REQ-1:0]                      req_ready,
  output logic [NUM_REQ-1:0]                      rsp_valid,
  input  logic [NUM_REQ-1:0]                      rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]           rsp_data,
  output logic [1:0]                              rsp_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]           m_araddr,
  output logic [2:0]                              m_arprot,
  output logic                                    m_arvalid,
  input  logic                                    m_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]           m_rdata,
  input  logic [1:0]                              m_rresp,
  input  logic                                    m_rvalid,
  output logic                                    m_rready,
  output logic [$clog2(NUM_REQ)-1:0]              grant_id,
  output logic                                    busy,
  output logic [CNT_WIDTH-1:0]                    err_count,
  output logic [CNT_WIDTH-1:0]                    txn_count
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic [AW-1:0]        araddr_q, araddr_d;
  logic [2:0]           arprot_q, arprot_d;
  logic                 arvalid_q, arvalid_d;
  logic                 rready_q, rready_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]        rsp_data_q, rsp_data_d;
  logic [1:0]           rsp_resp_q, rsp_resp_d;
  logic [CNT_WIDTH-1:0] err_q, err_d;
  logic [CNT_WIDTH-1:0] txn_q, txn_d;
  logic                 busy_q, busy_d;

  logic                 any_req_s;
  logic [IW-1:0]        gnt_idx_s;
  logic [IW:0]          cand_s;
  logic [NUM_REQ-1:0]   req_ready_s;

  // Round-robin search starting one past the last grant, wrapping modulo NUM_REQ.
  always_comb begin
    any_req_s = 1'b0;
    gnt_idx_s = {IW{1'b0}};
    cand_s    = {(IW+1){1'b0}};
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = {1'b0, ptr_q} + (IW+1)'(k);
      cand_s = (cand_s >= (IW+1)'(NUM_REQ)) ? (cand_s - (IW+1)'(NUM_REQ)) : cand_s;
      if (!any_req_s && req_valid[cand_s[IW-1:0]]) begin
        any_req_s = 1'b1;
        gnt_idx_s = cand_s[IW-1:0];
      end else begin
        any_req_s = any_req_s;
      end
    end
  end

  // Next-state and next-output logic for the read sequencing FSM.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    araddr_d    = araddr_q;
    arprot_d    = arprot_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_resp_d  = rsp_resp_q;
    err_d       = err_q;
    txn_d       = txn_q;
    req_ready_s = {NUM_REQ{1'b0}};

    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          req_ready_s[gnt_idx_s] = 1'b1;
          araddr_d  = req_addr[int'(gnt_idx_s)*AW +: AW];
          arprot_d  = req_prot[int'(gnt_idx_s)*3 +: 3];
          grant_d   = gnt_idx_s;
          ptr_d     = gnt_idx_s;
          arvalid_d = 1'b1;
          state_d   = ADDR;
        end else begin
          state_d   = IDLE;
        end
      end
      ADDR: begin
        // R beats cannot legally precede the AR handshake, so m_rvalid is not looked at here.
        if (arvalid_q && m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = DATA;
        end else begin
          state_d   = ADDR;
        end
      end
      DATA: begin
        if (m_rvalid) begin
          rsp_data_d           = m_rdata;
          rsp_resp_d           = m_rresp;
          rready_d             = 1'b0;
          rsp_valid_d          = {NUM_REQ{1'b0}};
          rsp_valid_d[grant_q] = 1'b1;
          if ((m_rresp != 2'b00) && (err_q != {CNT_WIDTH{1'b1}})) begin
            err_d = err_q + CNT_WIDTH'(1);
          end else begin
            err_d = err_q;
          end
          state_d = RESP;
        end else begin
          state_d = DATA;
        end
      end
      RESP: begin
        // Only the granted requester's rsp_ready completes the transaction.
        if (rsp_ready[grant_q]) begin
          rsp_valid_d = {NUM_REQ{1'b0}};
          txn_d       = txn_q + CNT_WIDTH'(1);
          state_d     = IDLE;
        end else begin
          state_d     = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = {NUM_REQ{1'b0}};
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      ptr_q       <= IW'(NUM_REQ - 1);
      grant_q     <= {IW{1'b0}};
      araddr_q    <= {AW{1'b0}};
      arprot_q    <= 3'b000;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= {NUM_REQ{1'b0}};
      rsp_data_q  <= {DW{1'b0}};
      rsp_resp_q  <= 2'b00;
      err_q       <= {CNT_WIDTH{1'b0}};
      txn_q       <= {CNT_WIDTH{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      araddr_q    <= araddr_d;
      arprot_q    <= arprot_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_resp_q  <= rsp_resp_d;
      err_q       <= err_d;
      txn_q       <= txn_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_resp  = rsp_resp_q;
  assign m_araddr  = araddr_q;
  assign m_arprot  = arprot_q;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;
  assign err_count = err_q;
  assign txn_count = txn_q;

endmodule

// File: tb/tb_axi_lite_read_arbiter.sv
// Self-checking bench for axi_lite_read_arbiter: vector table plus hand-written reset/saturation sequences.
// The bench plays the AXI slave and all local requesters, in lockstep with the clock.
module tb_axi_lite_read_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int CW = 8;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*3-1:0]   req_prot;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_ready;
  logic [DW-1:0]     rsp_data;
  logic [1:0]        rsp_resp;
  logic [AW-1:0]     m_araddr;
  logic [2:0]        m_arprot;
  logic              m_arvalid;
  logic              m_arready;
  logic [DW-1:0]     m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rvalid;
  logic              m_rready;
  logic [1:0]        grant_id;
  logic              busy;
  logic [CW-1:0]     err_count;
  logic [CW-1:0]     txn_count;

  always #5 aclk = ~aclk;

  axi_lite_read_arbiter #(
    .NUM_REQ(NR), .C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_addr(req_addr), .req_prot(req_prot), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .grant_id(grant_id), .busy(busy), .err_count(err_count), .txn_count(txn_count)
  );

  typedef struct {
    logic [3:0]  mask;
    logic [3:0]  next_mask;
    int          ar_dly;
    int          r_dly;
    int          rsp_dly;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          exp_g;
  } vec_t;

  typedef struct {
    int          g;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  vec_t       vecs[16];
  exp_t       sb_q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] err_m;
  logic [7:0] txn_m;
  logic [3:0] addr_tab[4];
  logic [2:0] prot_tab[4];
  int         obs_cnt[4];
  int         snap_cnt[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // One complete transaction; called one step after a rising edge with the DUT in IDLE.
  task automatic run_txn(input vec_t v);
    logic [3:0] oh;
    logic [3:0] ea;
    logic [2:0] ep;
    exp_t       e;
    int         g;
    g  = v.exp_g;
    oh = 4'b0001 << g;
    ea = addr_tab[g];
    ep = prot_tab[g];
    req_valid = v.mask;
    #1;
    chk("req_ready", 32'(req_ready), 32'(oh));
    chk("busy_idle", 32'(busy), 32'd0);
    e.g = g; e.data = v.rdata; e.resp = v.rresp;
    sb_q.push_back(e);
    @(posedge aclk); #1;
    chk("req_ready_pulse", 32'(req_ready), 32'd0);
    req_valid = v.next_mask;
    chk("arvalid", 32'(m_arvalid), 32'd1);
    chk("araddr", 32'(m_araddr), 32'(ea));
    chk("arprot", 32'(m_arprot), 32'(ep));
    chk("grant_id", 32'(grant_id), 32'(g));
    chk("busy_addr", 32'(busy), 32'd1);
    chk("rready_addr", 32'(m_rready), 32'd0);
    for (int i = 0; i < v.ar_dly; i++) begin
      m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b11;
      tick();
      chk("ar_hold_valid", 32'(m_arvalid), 32'd1);
      chk("ar_hold_addr", 32'(m_araddr), 32'(ea));
      chk("ar_hold_prot", 32'(m_arprot), 32'(ep));
      chk("ar_hold_rready", 32'(m_rready), 32'd0);
    end
    m_rvalid = 1'b0;
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    chk("arvalid_drop", 32'(m_arvalid), 32'd0);
    chk("rready_data", 32'(m_rready), 32'd1);
    for (int i = 0; i < v.r_dly; i++) begin
      tick();
      chk("r_wait_rready", 32'(m_rready), 32'd1);
      chk("r_wait_arvalid", 32'(m_arvalid), 32'd0);
      chk("r_wait_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    m_rvalid = 1'b1; m_rdata = v.rdata; m_rresp = v.rresp;
    if ((v.rresp != 2'b00) && (err_m != 8'hFF)) err_m = err_m + 8'd1;
    tick();
    m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
    if (sb_q.size() == 0) begin
      n_chk++;
      $display("FAIL sb_empty: response seen, no expectation queued");
      e.g = 0; e.data = 32'h0; e.resp = 2'b00;
    end else begin
      e = sb_q.pop_front();
    end
    for (int j = 0; j < NR; j++) if (rsp_valid[j]) obs_cnt[j]++;
    chk("rsp_valid", 32'(rsp_valid), 32'(4'b0001 << e.g));
    chk("rsp_data", rsp_data, e.data);
    chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
    chk("err_count", 32'(err_count), 32'(err_m));
    chk("rready_resp", 32'(m_rready), 32'd0);
    chk("arvalid_resp", 32'(m_arvalid), 32'd0);
    for (int i = 0; i < v.rsp_dly; i++) begin
      rsp_ready = ~oh;
      tick();
      chk("rsp_hold_valid", 32'(rsp_valid), 32'(oh));
      chk("rsp_hold_data", rsp_data, e.data);
      chk("rsp_hold_busy", 32'(busy), 32'd1);
    end
    rsp_ready = oh;
    tick();
    rsp_ready = 4'b0000;
    txn_m = txn_m + 8'd1;
    chk("rsp_valid_clear", 32'(rsp_valid), 32'd0);
    chk("busy_done", 32'(busy), 32'd0);
    chk("txn_count", 32'(txn_count), 32'(txn_m));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_arvalid"}, 32'(m_arvalid), 32'd0);
    chk({tag, "_rready"}, 32'(m_rready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_araddr"}, 32'(m_araddr), 32'd0);
    chk({tag, "_grant"}, 32'(grant_id), 32'd0);
    chk({tag, "_err"}, 32'(err_count), 32'd0);
    chk({tag, "_txn"}, 32'(txn_count), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t sat;
    addr_tab[0] = 4'd12; addr_tab[1] = 4'd5;  addr_tab[2] = 4'd9;  addr_tab[3] = 4'd3;
    prot_tab[0] = 3'b000; prot_tab[1] = 3'b101; prot_tab[2] = 3'b010; prot_tab[3] = 3'b111;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = addr_tab[i];
      req_prot[i*3 +: 3]   = prot_tab[i];
      obs_cnt[i] = 0;
    end

    vecs[0] = '{4'b0001, 4'b0000, 0, 0, 0, 32'hA5A5_A5A5, 2'b00, 0};
    vecs[1] = '{4'b1000, 4'b0000, 0, 0, 0, 32'h0000_0003, 2'b00, 3};
    for (int i = 0; i < 8; i++) begin
      vecs[2+i] = '{4'b1111, 4'b1111, (i == 1) ? 1 : 0, (i == 3) ? 2 : 0, (i == 5) ? 1 : 0,
                    32'h0000_1000 + 32'(i), 2'b00, i % 4};
    end
    vecs[10] = '{4'b0100, 4'b0000, 5, 3, 4, 32'h1234_5678, 2'b00, 2};
    vecs[11] = '{4'b0010, 4'b0000, 0, 1, 0, 32'h0BAD_0BAD, 2'b10, 1};
    vecs[12] = '{4'b0010, 4'b0110, 1, 0, 0, 32'h0000_0012, 2'b00, 1};
    vecs[13] = '{4'b0110, 4'b0000, 0, 0, 2, 32'h0000_0013, 2'b11, 2};
    vecs[14] = '{4'b1000, 4'b0000, 0, 1, 0, 32'h0000_0014, 2'b01, 3};
    vecs[15] = '{4'b1001, 4'b0000, 0, 0, 0, 32'h0000_0015, 2'b00, 0};

    aresetn = 1'b0; req_valid = 4'b0000; rsp_ready = 4'b0000;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
    err_m = 8'd0; txn_m = 8'd0;
    tick(); tick();
    chk_reset_state("reset");
    aresetn = 1'b1;
    tick();

    req_valid = 4'b0000;
    tick(); tick();
    chk("idle_no_req_ready", 32'(req_ready), 32'd0);
    chk("idle_no_req_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 16; i++) begin
      if (i == 2) for (int j = 0; j < NR; j++) snap_cnt[j] = obs_cnt[j];
      run_txn(vecs[i]);
      if (i == 9) begin
        for (int j = 0; j < NR; j++) chk("rr_share", 32'(obs_cnt[j] - snap_cnt[j]), 32'd2);
      end
    end

    // Drive the error counter to saturation, then one more error.
    sat = '{4'b0001, 4'b0000, 0, 0, 0, 32'h0, 2'b10, 0};
    for (int i = 0; i < 300 && err_m != 8'hFF; i++) begin
      sat.rdata = 32'h5A00_0000 + 32'(i);
      run_txn(sat);
    end
    sat.rdata = 32'h5AFF_FFFF;
    run_txn(sat);
    chk("err_saturated", 32'(err_count), 32'h0000_00FF);

    // Reset while the FSM waits for the R beat.
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    chk("pre_rst_rready", 32'(m_rready), 32'd1);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    chk_reset_state("rst_data");
    err_m = 8'd0; txn_m = 8'd0;
    sb_q.delete();
    run_txn('{4'b1001, 4'b0000, 0, 0, 0, 32'hC0DE_0001, 2'b00, 0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
